// File: rtl/mem_stage_mc.sv
// Purpose : memory stage of the pipelined core, sequencing each load/store as a
//           request/response transaction to a multi-cycle data memory or cache.
// Latency : 3 stall cycles minimum (detect, REQ, WAIT); Stall drops in the DONE cycle.
// Backpres: Stall holds the pipeline while MReady or MRValid stay low; WAIT is bounded by TIMEOUT.
//
// Ports
//   clk, rst           clock; asynchronous active-low reset
//   InValid, Halt      instruction present in M / it is a halt
//   MemRW              00 none, 10 read, 01 or 11 write
//   ALUOut, Rt         access address / store data (sampled only in IDLE)
//   MemOut             last load result, registered
//   Stall              combinational hold request to the pipeline
//   Err                one-cycle pulse on misaligned access or response timeout
//   CreateDump         one-cycle memory-dump request after a halt
//   StallCnt           saturating count of Stall-high cycles
//   MReq/MWr/MAddr/MWData  request channel, stable while MReq is high
//   MReady             memory accepts the request
//   MRValid/MRData     read data or write acknowledge

module mem_stage_mc #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int ALIGN_CHK = 1,
    parameter int TIMEOUT   = 64,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              InValid,
    input  logic              Halt,
    input  logic [1:0]        MemRW,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] Rt,
    output logic [DATA_W-1:0] MemOut,
    output logic              Stall,
    output logic              Err,
    output logic              CreateDump,
    output logic [CNT_W-1:0]  StallCnt,
    output logic              MReq,
    output logic              MWr,
    output logic [ADDR_W-1:0] MAddr,
    output logic [DATA_W-1:0] MWData,
    input  logic              MReady,
    input  logic              MRValid,
    input  logic [DATA_W-1:0] MRData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DUMP,
        S_HALTED
    } state_t;

    // Byte-odd addresses are only illegal for 16-bit words.
    localparam logic CHK_EN = (ALIGN_CHK != 0) && (DATA_W == 16);
    localparam logic TO_EN  = (TIMEOUT != 0);
    // The counter only has to reach TIMEOUT-1: the TIMEOUT-th WAIT cycle
    // is the one that aborts.
    localparam int   TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wr;
    logic [TO_W-1:0]   to_cnt;

    logic access;
    logic misaligned;
    logic in_idle;
    logic idle_start;
    logic idle_misalign;
    logic timeout_hit;
    logic wait_timeout;

    // ------------------------------------------------------------------
    // Decode of the instruction presented in IDLE
    // ------------------------------------------------------------------
    assign access        = (MemRW != 2'b00);
    assign misaligned    = CHK_EN & ALUOut[0];
    assign in_idle       = (state == S_IDLE);
    // Halt wins over an access presented in the same cycle.
    assign idle_start    = in_idle & InValid & ~Halt & access & ~misaligned;
    assign idle_misalign = in_idle & InValid & ~Halt & access & misaligned;

    assign timeout_hit   = TO_EN & (to_cnt == TO_LAST);
    // A response arriving on the last allowed cycle still counts as success.
    assign wait_timeout  = (state == S_WAIT) & ~MRValid & timeout_hit;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Stall and Err depend on the live inputs in IDLE, so they are gated
    // by rst to read 0 the moment reset is asserted.
    assign Stall      = rst & (idle_start | (state == S_REQ) | (state == S_WAIT));
    assign Err        = rst & (idle_misalign | wait_timeout);
    assign MReq       = (state == S_REQ);
    assign CreateDump = (state == S_DUMP);
    assign MWr        = req_wr;
    assign MAddr      = req_addr;
    assign MWData     = req_wdata;

    // ------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wr    <= 1'b0;
            to_cnt    <= '0;
            MemOut    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (InValid && Halt) begin
                        state <= S_DUMP;
                    end else if (idle_start) begin
                        // The pipeline holds its inputs while stalled, but
                        // the request is driven from these copies only.
                        req_addr  <= ALUOut;
                        req_wdata <= Rt;
                        req_wr    <= MemRW[0];
                        state     <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (MReady) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (MRValid) begin
                        if (!req_wr) begin
                            MemOut <= MRData;
                        end
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        state <= S_DONE;
                    end else if (TO_EN) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_DONE: begin
                    to_cnt <= '0;
                    state  <= S_IDLE;
                end

                S_DUMP: begin
                    state <= S_HALTED;
                end

                S_HALTED: begin
                    state <= S_HALTED;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stall-cycle counter, sticks at all-ones
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
        end else if (Stall && (StallCnt != {CNT_W{1'b1}})) begin
            StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Purpose : randomized check of mem_stage_mc against a transaction-level model.
// Latency : each access expectation is built from its ready/response delays.
// Backpres: the bench plays the memory, holding MReady/MRValid low at random.

module tb_mem_stage_mc;

    localparam int DW  = 16;
    localparam int AW  = 16;
    localparam int TO  = 4;
    localparam int CW  = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          InValid, Halt;
    logic [1:0]    MemRW;
    logic [AW-1:0] ALUOut;
    logic [DW-1:0] Rt;
    logic [DW-1:0] MemOut;
    logic          Stall, Err, CreateDump;
    logic [CW-1:0] StallCnt;
    logic          MReq, MWr;
    logic [AW-1:0] MAddr;
    logic [DW-1:0] MWData;
    logic          MReady, MRValid;
    logic [DW-1:0] MRData;

    mem_stage_mc #(
        .DATA_W(DW), .ADDR_W(AW), .ALIGN_CHK(1), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .InValid(InValid), .Halt(Halt), .MemRW(MemRW),
        .ALUOut(ALUOut), .Rt(Rt), .MemOut(MemOut), .Stall(Stall), .Err(Err),
        .CreateDump(CreateDump), .StallCnt(StallCnt), .MReq(MReq), .MWr(MWr),
        .MAddr(MAddr), .MWData(MWData), .MReady(MReady), .MRValid(MRValid),
        .MRData(MRData)
    );

    always #5 clk = ~clk;

    // Expected outputs for the current cycle, set by the driver.
    logic          exp_stall, exp_mreq, exp_err, exp_dump, exp_mwr;
    logic [AW-1:0] exp_maddr;
    logic [DW-1:0] exp_mwdata;
    logic [DW-1:0] m_memout;
    // Literal pins checked in a chosen DONE cycle.
    logic          pin_en = 1'b0;
    int            pin_run, pin_cnt;
    logic [DW-1:0] pin_mem;

    int n_tests = 0;
    int n_fail  = 0;
    int model_cnt;
    int run;
    logic prev_rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare process: every negedge while out of reset, plus an immediate
    // check whenever reset is asserted.
    initial begin
        prev_rst  = 1'b1;
        model_cnt = 0;
        run       = 0;
        forever begin
            @(negedge clk or negedge rst);
            if (!rst) begin
                if (prev_rst) begin
                    #1;
                    chk("rst_stall",    32'(Stall),      32'd0);
                    chk("rst_mreq",     32'(MReq),       32'd0);
                    chk("rst_err",      32'(Err),        32'd0);
                    chk("rst_dump",     32'(CreateDump), 32'd0);
                    chk("rst_memout",   32'(MemOut),     32'd0);
                    chk("rst_stallcnt", 32'(StallCnt),   32'd0);
                end
                model_cnt = 0;
                run       = 0;
            end else begin
                chk("stall",    32'(Stall),      32'(exp_stall));
                chk("mreq",     32'(MReq),       32'(exp_mreq));
                chk("err",      32'(Err),        32'(exp_err));
                chk("dump",     32'(CreateDump), 32'(exp_dump));
                chk("memout",   32'(MemOut),     32'(m_memout));
                chk("stallcnt", 32'(StallCnt),   32'(model_cnt));
                if (exp_mreq) begin
                    chk("mwr",    32'(MWr),    32'(exp_mwr));
                    chk("maddr",  32'(MAddr),  32'(exp_maddr));
                    chk("mwdata", 32'(MWData), 32'(exp_mwdata));
                end
                if (pin_en) begin
                    chk("pin_run",    32'(run),      32'(pin_run));
                    chk("pin_cnt",    32'(StallCnt), 32'(pin_cnt));
                    chk("pin_memout", 32'(MemOut),   32'(pin_mem));
                end
                if (Stall === 1'b1) run++;
                else                run = 0;
                if (exp_stall && model_cnt < CNT_MAX) model_cnt++;
            end
            prev_rst = rst;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_o(input bit st, input bit rq, input bit er, input bit dp);
        exp_stall = st;
        exp_mreq  = rq;
        exp_err   = er;
        exp_dump  = dp;
    endtask

    // Memory side with nothing outstanding: stray responses only.
    task automatic mem_quiet();
        MReady  = 1'b0;
        MRValid = ($urandom_range(0, 3) == 0);
        MRData  = 16'($urandom);
    endtask

    task automatic do_idle(input bit nop);
        InValid = nop;
        Halt    = nop ? 1'b0 : 1'($urandom_range(0, 1));
        MemRW   = nop ? 2'b00 : 2'($urandom_range(0, 3));
        ALUOut  = 16'($urandom);
        Rt      = 16'($urandom);
        mem_quiet();
        expect_o(0, 0, 0, 0);
        step();
    endtask

    // One access: rdly MReady-low cycles in REQ, then vdly MRValid-low cycles
    // in WAIT before the response (vdly >= TO means no response at all).
    task automatic do_access(input logic [1:0] rw, input logic [AW-1:0] addr,
                             input logic [DW-1:0] data, input int rdly, input int vdly,
                             input logic [DW-1:0] rdata,
                             input int p_run, input int p_cnt, input int p_mem);
        int w;
        bit tmo;
        InValid = 1'b1;
        Halt    = 1'b0;
        MemRW   = rw;
        ALUOut  = addr;
        Rt      = data;
        mem_quiet();
        if (addr[0]) begin
            expect_o(0, 0, 1, 0);
            step();
            return;
        end
        expect_o(1, 0, 0, 0);
        step();
        exp_mwr    = rw[0];
        exp_maddr  = addr;
        exp_mwdata = data;
        for (int i = 0; i <= rdly; i++) begin
            MReady  = (i == rdly);
            MRValid = (i != rdly) && ($urandom_range(0, 3) == 0);
            MRData  = 16'($urandom);
            expect_o(1, 1, 0, 0);
            step();
        end
        tmo = (vdly >= TO);
        w   = tmo ? TO : vdly + 1;
        for (int i = 0; i < w; i++) begin
            MReady  = 1'b0;
            MRValid = !tmo && (i == vdly);
            MRData  = MRValid ? rdata : 16'($urandom);
            expect_o(1, 0, tmo && (i == w - 1), 0);
            step();
            if (!tmo && (i == vdly) && !rw[0]) m_memout = rdata;
        end
        mem_quiet();
        expect_o(0, 0, 0, 0);
        pin_en  = (p_run >= 0);
        pin_run = p_run;
        pin_cnt = p_cnt;
        pin_mem = 16'(p_mem);
        step();
        pin_en = 1'b0;
    endtask

    int            k;
    logic [1:0]    rw;
    logic [AW-1:0] addr;

    initial begin
        InValid = 0; Halt = 0; MemRW = 0; ALUOut = 0; Rt = 0;
        MReady = 0; MRValid = 0; MRData = 0;
        m_memout = '0;
        expect_o(0, 0, 0, 0);
        exp_mwr = 0; exp_maddr = 0; exp_mwdata = 0;
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        do_idle(1);

        // Directed: fastest read, slow-accept write, misaligned read, timeout.
        do_access(2'b10, 16'h0020, 16'h0000, 0, 0, 16'hBEEF, 3, 3, 16'hBEEF);
        do_access(2'b01, 16'h0010, 16'h1234, 2, 0, 16'h0000, 5, 8, 16'hBEEF);
        do_access(2'b10, 16'h0003, 16'h0000, 0, 0, 16'h5555, -1, 0, 0);
        do_access(2'b10, 16'h0030, 16'h0000, 0, TO, 16'h0000, 6, 14, 16'hBEEF);

        // Random traffic; long enough for StallCnt to saturate.
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k < 2)      do_idle(0);
            else if (k < 3) do_idle(1);
            else begin
                rw   = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom_range(1, 3));
                addr = 16'($urandom);
                if ($urandom_range(0, 7) != 0) addr[0] = 1'b0;
                do_access(rw, addr, 16'($urandom), $urandom_range(0, 3),
                          $urandom_range(0, 5), 16'($urandom), -1, 0, 0);
            end
        end

        // Reset in the middle of WAIT, then a clean read.
        do_access(2'b10, 16'h0050, 16'h0000, 0, 1, 16'h7E57, -1, 0, 0);
        InValid = 1; Halt = 0; MemRW = 2'b10; ALUOut = 16'h0040; Rt = 16'h0;
        mem_quiet();
        expect_o(1, 0, 0, 0);
        step();
        MReady = 1'b1; MRValid = 1'b0;
        exp_mwr = 1'b0; exp_maddr = 16'h0040; exp_mwdata = 16'h0;
        expect_o(1, 1, 0, 0);
        step();
        MReady = 1'b0; MRValid = 1'b0;
        expect_o(1, 0, 0, 0);
        step();
        step();
        #2 rst = 1'b0;
        m_memout = '0;
        step();
        do_idle(1);
        #0 rst = 1'b1;
        do_access(2'b10, 16'h0060, 16'h0000, 0, 0, 16'hA5C3, 3, 3, 16'hA5C3);
        do_idle(0);

        // Halt together with a read, then everything is ignored.
        InValid = 1; Halt = 1; MemRW = 2'b10; ALUOut = 16'h0070; Rt = 16'h0;
        mem_quiet();
        expect_o(0, 0, 0, 0);
        step();
        Halt = 0; ALUOut = 16'h0072;
        mem_quiet();
        expect_o(0, 0, 0, 1);
        step();
        for (int i = 0; i < 20; i++) begin
            InValid = 1;
            Halt    = 1'($urandom_range(0, 1));
            MemRW   = 2'($urandom_range(1, 3));
            ALUOut  = 16'($urandom);
            Rt      = 16'($urandom);
            MReady  = 1'($urandom_range(0, 1));
            MRValid = !MReady && ($urandom_range(0, 1) == 1);
            MRData  = 16'($urandom);
            expect_o(0, 0, 0, 0);
            step();
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_mc.md
Name: mem_stage_mc

Overview:
- Memory-stage block for the pipelined core, replacing the single-cycle data-memory hookup with a request/response handshake to a multi-cycle data memory or cache.
- Sequences each load/store through an FSM and stalls the pipeline until the access completes.
- Detects misaligned accesses and response timeouts, counts stall cycles, and issues the halt-time memory dump.
- Branch-condition logic stays in its own block and is outside this scope.

Parameters:
DATA_W, 16, data width in bits
ADDR_W, 16, address width in bits
ALIGN_CHK, 1, 1 = flag and drop accesses with ALUOut[0]=1 (only meaningful when DATA_W=16)
TIMEOUT, 64, maximum WAIT cycles before abort; 0 disables the timeout
CNT_W, 16, stall-counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
InValid  in  1  a valid instruction occupies the M stage
Halt  in  1  halt instruction in the M stage
MemRW  in  2  00 none, 10 read, 01 or 11 write
ALUOut  in  ADDR_W  access address
Rt  in  DATA_W  store data
MemOut  out  DATA_W  load result, registered
Stall  out  1  hold the pipeline
Err  out  1  one-cycle pulse: misaligned access or timeout
CreateDump  out  1  one-cycle dump request to the memory model
StallCnt  out  CNT_W  saturating count of Stall-high cycles
MReq  out  1  memory request valid
MWr  out  1  request is a write
MAddr  out  ADDR_W  request address
MWData  out  DATA_W  request write data
MReady  in  1  memory accepts the request this cycle
MRValid  in  1  read data valid or write acknowledge
MRData  in  DATA_W  read data

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - MemOut, StallCnt, and the timeout counter are cleared to 0.
  - MReq, Err, and CreateDump are 0.
  - Because Stall is combinational from the FSM, it is 0 immediately.
- A reset mid-access abandons the transaction. MReq drops immediately, and the memory side is reset by the same rst.
- FSM states are IDLE, REQ, WAIT, DONE, DUMP and HALTED.

IDLE:
- InValid & Halt: go to DUMP; Stall=0. Halt has priority over a simultaneous access.
- InValid & access & misaligned (ALIGN_CHK=1, ALUOut[0]=1): Err=1 for this cycle, no request, Stall=0, stay in IDLE.
- InValid & access otherwise: Stall=1; latch ALUOut, Rt, and the write flag into the request registers; go to REQ.

REQ:
- MReq=1 with MAddr, MWData, MWr from the request registers; Stall=1.
- MReady=1: go to WAIT. Otherwise hold all request outputs stable.

WAIT:
- MReq=0; Stall=1; the timeout counter increments each cycle.
- MRValid=1: on a read, MemOut<=MRData; go to DONE.
- Timeout (TIMEOUT≠0 and count reaches TIMEOUT without MRValid): Err=1 for one cycle, MemOut unchanged, go to DONE.
- Memory never asserts MRValid in the same cycle as MReady.

DONE:
- Stall=0 and the pipeline advances; clear the timeout counter; go to IDLE.
- Writes never modify MemOut. MemOut holds the last load value.

DUMP:
- CreateDump=1 for exactly one cycle; go to HALTED.

HALTED:
- Terminal until reset. No requests, Stall=0, CreateDump=0.

Timing and counters:
- Minimum access latency is 3 stall cycles (IDLE-detect, REQ, WAIT), with Stall low in the DONE cycle. Each extra MReady-low or MRValid-low cycle adds one stall cycle.
- StallCnt increments on every cycle with Stall=1 and saturates at all-ones, without wrapping.

Pipeline and memory constraints:
- The pipeline holds InValid, MemRW, ALUOut, and Rt stable while Stall=1. The block still uses only its latched copies.
- Stray MRValid pulses in IDLE, REQ, DONE, or HALTED are ignored.

Test Plan:
- Read with MReady=1 in REQ and MRValid next cycle, MRData=16'hBEEF: Stall high exactly 3 cycles, MemOut=16'hBEEF in the DONE cycle, StallCnt=3.
- Write at addr 16'h0010, data 16'h1234, with MReady held low for 2 cycles: MReq/MAddr/MWData/MWr=1 stable throughout REQ, Stall high 5 cycles, MemOut unchanged from its prior value.
- Read at addr 16'h0003 with ALIGN_CHK=1: Err pulses 1 cycle, MReq never asserts, Stall stays 0.
- Read with TIMEOUT=4 and MRValid never asserted: Err pulses after 4 WAIT cycles, then one DONE cycle with Stall=0, then IDLE.
- Halt and read presented together: no MReq, CreateDump=1 for exactly one cycle; later read requests are ignored with Stall=0.
- rst=0 asserted during WAIT: Stall, MReq, and MemOut go to 0 asynchronously; after release, a new read completes normally.
